// File: rtl/dmem_arbiter_if.sv
// Bus bundle between two load/store requesters, the arbiter and a single data memory port.
// The arbiter connects through the slave modport; the requester/memory side uses master.
interface dmem_arbiter_if #(
  parameter int unsigned addrWidth = 32,
  parameter int unsigned dataWidth = 32
) ();
  logic                 p0_reqValid;
  logic                 p0_reqReady;
  logic [addrWidth-1:0] p0_addr;
  logic [dataWidth-1:0] p0_wdata;
  logic [2:0]           p0_memOp;
  logic                 p0_we;
  logic                 p0_rspValid;
  logic                 p0_rspReady;
  logic [dataWidth-1:0] p0_rdata;
  logic                 p0_rspErr;

  logic                 p1_reqValid;
  logic                 p1_reqReady;
  logic [addrWidth-1:0] p1_addr;
  logic [dataWidth-1:0] p1_wdata;
  logic [2:0]           p1_memOp;
  logic                 p1_we;
  logic                 p1_rspValid;
  logic                 p1_rspReady;
  logic [dataWidth-1:0] p1_rdata;
  logic                 p1_rspErr;

  logic [addrWidth-1:0] mem_addr;
  logic [dataWidth-1:0] mem_din;
  logic [2:0]           mem_memOp;
  logic                 mem_we;
  logic [dataWidth-1:0] mem_dout;

  modport slave (
    input  p0_reqValid, p0_addr, p0_wdata, p0_memOp, p0_we, p0_rspReady,
    output p0_reqReady, p0_rspValid, p0_rdata, p0_rspErr,
    input  p1_reqValid, p1_addr, p1_wdata, p1_memOp, p1_we, p1_rspReady,
    output p1_reqReady, p1_rspValid, p1_rdata, p1_rspErr,
    output mem_addr, mem_din, mem_memOp, mem_we,
    input  mem_dout
  );

  modport master (
    output p0_reqValid, p0_addr, p0_wdata, p0_memOp, p0_we, p0_rspReady,
    input  p0_reqReady, p0_rspValid, p0_rdata, p0_rspErr,
    output p1_reqValid, p1_addr, p1_wdata, p1_memOp, p1_we, p1_rspReady,
    input  p1_reqReady, p1_rspValid, p1_rdata, p1_rspErr,
    input  mem_addr, mem_din, mem_memOp, mem_we,
    output mem_dout
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-requester round-robin arbiter in front of a single data memory port.
// One transaction in flight at a time; illegal/misaligned requests are answered
// with an error response without touching memory.
module dmem_arbiter #(
  parameter int unsigned addrWidth = 32,
  parameter int unsigned dataWidth = 32
) (
  input  logic          clk,
  input  logic          rst,
  dmem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e               state_q, state_d;
  logic                 ptr_q, ptr_d;
  logic                 owner_q, owner_d;
  logic [addrWidth-1:0] addr_q, addr_d;
  logic [dataWidth-1:0] wdata_q, wdata_d;
  logic [2:0]           op_q, op_d;
  logic                 we_q, we_d;
  logic [dataWidth-1:0] rdata_q, rdata_d;
  logic                 err_q, err_d;

  logic [1:0]           valid;
  logic                 gnt;
  logic                 take;
  logic [addrWidth-1:0] sel_addr;
  logic [dataWidth-1:0] sel_wdata;
  logic [2:0]           sel_op;
  logic                 sel_we;
  logic                 sel_err;
  logic                 own_rsp_ready;

  function automatic logic is_illegal(input logic [2:0] op, input logic [1:0] lsb);
    logic ill;
    case (op)
      3'd0, 3'd4: ill = 1'b0;
      3'd1, 3'd5: ill = lsb[0];
      3'd2:       ill = (lsb != 2'b00);
      default:    ill = 1'b1;
    endcase
    return ill;
  endfunction

  // Round-robin pick and mux of the winning request fields
  always_comb begin
    valid = {bus.p1_reqValid, bus.p0_reqValid};
    // A lone requester wins regardless of the pointer
    gnt       = (valid == 2'b11) ? ptr_q : valid[1];
    take      = !rst && (state_q == StIdle) && (valid != 2'b00);
    sel_addr  = gnt ? bus.p1_addr  : bus.p0_addr;
    sel_wdata = gnt ? bus.p1_wdata : bus.p0_wdata;
    sel_op    = gnt ? bus.p1_memOp : bus.p0_memOp;
    sel_we    = gnt ? bus.p1_we    : bus.p0_we;
    sel_err   = is_illegal(sel_op, sel_addr[1:0]);
    own_rsp_ready = owner_q ? bus.p1_rspReady : bus.p0_rspReady;
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (take) state_d = sel_err ? StResp : StIssue;
      StIssue: state_d = we_q ? StResp : StWait;
      StWait:  state_d = StResp;
      StResp:  if (own_rsp_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Next values for the latched request, pointer and response
  always_comb begin
    ptr_d   = ptr_q;
    owner_d = owner_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    op_d    = op_q;
    we_d    = we_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    if (take) begin
      ptr_d   = ~gnt;
      owner_d = gnt;
      addr_d  = sel_addr;
      wdata_d = sel_wdata;
      op_d    = sel_op;
      we_d    = sel_we;
      rdata_d = '0;
      err_d   = sel_err;
    end else if (state_q == StWait) begin
      rdata_d = bus.mem_dout;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q   <= 1'b0;
      owner_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      op_q    <= '0;
      we_q    <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      op_q    <= op_d;
      we_q    <= we_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // FSM outputs: handshakes, memory strobe and per-requester response
  always_comb begin
    bus.p0_reqReady = take && !gnt;
    bus.p1_reqReady = take && gnt;
    bus.p0_rspValid = (state_q == StResp) && !owner_q;
    bus.p1_rspValid = (state_q == StResp) && owner_q;
    bus.p0_rdata    = bus.p0_rspValid ? rdata_q : '0;
    bus.p1_rdata    = bus.p1_rspValid ? rdata_q : '0;
    bus.p0_rspErr   = bus.p0_rspValid && err_q;
    bus.p1_rspErr   = bus.p1_rspValid && err_q;
    bus.mem_addr    = addr_q;
    bus.mem_din     = wdata_q;
    bus.mem_memOp   = op_q;
    bus.mem_we      = (state_q == StIssue) && we_q;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: reset state, directed multi-cycle sequences,
// a table of single transactions and a randomized run against a transaction-level model.
module tb_dmem_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.addrWidth(32), .dataWidth(32)) bus ();
  dmem_arbiter #(.addrWidth(32), .dataWidth(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  logic [1:0]  req_valid, we, rsp_ready;
  logic [31:0] addr [2];
  logic [31:0] wdata [2];
  logic [2:0]  op [2];
  logic        use_model;
  logic [31:0] dout_drv;

  // Memory contents as a pure function of address and op
  function automatic logic [31:0] memf(input logic [31:0] a, input logic [2:0] o);
    return {a[23:0] ^ 24'hA5C3E1, 5'd0, o};
  endfunction

  assign bus.p0_reqValid = req_valid[0];
  assign bus.p1_reqValid = req_valid[1];
  assign bus.p0_addr     = addr[0];
  assign bus.p1_addr     = addr[1];
  assign bus.p0_wdata    = wdata[0];
  assign bus.p1_wdata    = wdata[1];
  assign bus.p0_memOp    = op[0];
  assign bus.p1_memOp    = op[1];
  assign bus.p0_we       = we[0];
  assign bus.p1_we       = we[1];
  assign bus.p0_rspReady = rsp_ready[0];
  assign bus.p1_rspReady = rsp_ready[1];
  assign bus.mem_dout    = use_model ? memf(bus.mem_addr, bus.mem_memOp) : dout_drv;

  wire [1:0] rq_rdy = {bus.p1_reqReady, bus.p0_reqReady};
  wire [1:0] rs_vld = {bus.p1_rspValid, bus.p0_rspValid};
  wire [1:0] rs_err = {bus.p1_rspErr, bus.p0_rspErr};
  logic [31:0] rdat [2];
  assign rdat[0] = bus.p0_rdata;
  assign rdat[1] = bus.p1_rdata;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic to_neg();
    @(negedge clk);
  endtask

  task automatic to_drive();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_valid = 2'b00;
    we        = 2'b00;
    rsp_ready = 2'b00;
    for (int n = 0; n < 2; n++) begin
      addr[n]  = '0;
      wdata[n] = '0;
      op[n]    = 3'd2;
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " reqReady"}, rq_rdy, 2'b00);
    chk({tag, " rspValid"}, rs_vld, 2'b00);
    chk({tag, " rspErr"}, rs_err, 2'b00);
    chk({tag, " rdata0"}, rdat[0], 32'h0);
    chk({tag, " rdata1"}, rdat[1], 32'h0);
    chk({tag, " mem_we"}, bus.mem_we, 1'b0);
    chk({tag, " mem_addr"}, bus.mem_addr, 32'h0);
    chk({tag, " mem_din"}, bus.mem_din, 32'h0);
    chk({tag, " mem_memOp"}, bus.mem_memOp, 3'h0);
  endtask

  typedef struct {
    logic        who;
    logic [2:0]  op;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] dout;
    logic        err;
    logic [31:0] rdata;
    int          lat;
    int          nwe;
  } vec_t;

  vec_t tbl [11];

  // One transaction from a single requester with rspReady held high
  task automatic run_single(input vec_t v, input int idx);
    int cyc;
    int nwe;
    bit seen;
    to_drive();
    req_valid     = 2'b00;
    req_valid[v.who] = 1'b1;
    addr[v.who]   = v.addr;
    wdata[v.who]  = v.wdata;
    op[v.who]     = v.op;
    we[v.who]     = v.we;
    rsp_ready     = 2'b11;
    use_model     = 1'b0;
    dout_drv      = v.dout;
    to_neg();
    chk($sformatf("v%0d grant", idx), rq_rdy, v.who ? 2'b10 : 2'b01);
    to_drive();
    req_valid = 2'b00;
    cyc  = 0;
    nwe  = 0;
    seen = 0;
    while (!seen && cyc < 8) begin
      to_neg();
      cyc++;
      if (bus.mem_we) begin
        nwe++;
        chk($sformatf("v%0d mem_din", idx), bus.mem_din, v.wdata);
        chk($sformatf("v%0d mem_addr", idx), bus.mem_addr, v.addr);
      end
      if (rs_vld != 2'b00) seen = 1;
    end
    chk($sformatf("v%0d latency", idx), cyc, v.lat);
    chk($sformatf("v%0d rspValid", idx), rs_vld, v.who ? 2'b10 : 2'b01);
    chk($sformatf("v%0d rdata", idx), rdat[v.who], v.rdata);
    chk($sformatf("v%0d rspErr", idx), rs_err[v.who], v.err);
    to_neg();
    if (bus.mem_we) nwe++;
    chk($sformatf("v%0d mem_we cycles", idx), nwe, v.nwe);
    chk($sformatf("v%0d idle rspValid", idx), rs_vld, 2'b00);
  endtask

  // Transaction-level reference model state for the random run
  bit          m_busy;
  bit          m_owner;
  bit          m_ptr;
  int          m_age;
  int          m_lat;
  bit          m_err;
  bit          m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [2:0]  m_op;
  logic [31:0] m_rdata;

  function automatic bit ref_illegal(input logic [2:0] o, input logic [31:0] a);
    if (o == 3'd0 || o == 3'd4) return 1'b0;
    if (o == 3'd1 || o == 3'd5) return a % 2 != 0;
    if (o == 3'd2) return a % 4 != 0;
    return 1'b1;
  endfunction

  initial begin
    bit       granted;
    bit       g;
    logic [1:0] exp_rdy;

    tbl[0]  = '{1'b1, 3'd2, 1'b1, 32'h8,  32'hDEADBEEF, 32'hFFFFFFFF, 1'b0, 32'h0,        2, 1};
    tbl[1]  = '{1'b1, 3'd2, 1'b0, 32'h8,  32'h0,        32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 3, 0};
    tbl[2]  = '{1'b0, 3'd1, 1'b0, 32'h3,  32'h0,        32'h12345678, 1'b1, 32'h0,        1, 0};
    tbl[3]  = '{1'b0, 3'd0, 1'b0, 32'h7,  32'h0,        32'hFFFFFF80, 1'b0, 32'hFFFFFF80, 3, 0};
    tbl[4]  = '{1'b0, 3'd1, 1'b1, 32'h6,  32'h1234,     32'hFFFFFFFF, 1'b0, 32'h0,        2, 1};
    tbl[5]  = '{1'b1, 3'd2, 1'b0, 32'h2,  32'h0,        32'h11111111, 1'b1, 32'h0,        1, 0};
    tbl[6]  = '{1'b0, 3'd5, 1'b0, 32'h4,  32'h0,        32'h0000BEEF, 1'b0, 32'h0000BEEF, 3, 0};
    tbl[7]  = '{1'b1, 3'd0, 1'b1, 32'h13, 32'hA5,       32'hFFFFFFFF, 1'b0, 32'h0,        2, 1};
    tbl[8]  = '{1'b1, 3'd6, 1'b0, 32'h0,  32'h0,        32'h22222222, 1'b1, 32'h0,        1, 0};
    tbl[9]  = '{1'b0, 3'd7, 1'b1, 32'h0,  32'h55,       32'h33333333, 1'b1, 32'h0,        1, 0};
    tbl[10] = '{1'b1, 3'd3, 1'b0, 32'h0,  32'h0,        32'h44444444, 1'b1, 32'h0,        1, 0};

    // Reset state
    rst       = 1'b1;
    use_model = 1'b1;
    dout_drv  = '0;
    idle_inputs();
    to_neg();
    chk_all_zero("reset");
    to_drive();
    rst = 1'b0;
    to_neg();
    chk_all_zero("post-reset");

    // Contention from reset: p0 first, then p1, strictly serialized
    to_drive();
    req_valid = 2'b11;
    addr[0]   = 32'h10;
    addr[1]   = 32'h20;
    rsp_ready = 2'b11;
    to_neg();
    chk("A grant p0", rq_rdy, 2'b01);
    to_drive();
    req_valid[0] = 1'b0;
    to_neg();
    chk("A issue reqReady", rq_rdy, 2'b00);
    chk("A issue mem_addr", bus.mem_addr, 32'h10);
    chk("A load mem_we", bus.mem_we, 1'b0);
    to_neg();
    chk("A wait rspValid", rs_vld, 2'b00);
    to_neg();
    chk("A p0 rspValid", rs_vld, 2'b01);
    chk("A p0 rdata", rdat[0], memf(32'h10, 3'd2));
    chk("A resp reqReady", rq_rdy, 2'b00);
    to_neg();
    chk("A grant p1", rq_rdy, 2'b10);
    to_drive();
    req_valid[1] = 1'b0;
    to_neg();
    chk("A issue2 mem_addr", bus.mem_addr, 32'h20);
    to_neg();
    to_neg();
    chk("A p1 rspValid", rs_vld, 2'b10);
    chk("A p1 rdata", rdat[1], memf(32'h20, 3'd2));
    to_neg();
    chk("A idle rspValid", rs_vld, 2'b00);

    // Table of single transactions (store/load, misalignment, illegal ops)
    for (int i = 0; i < 11; i++) run_single(tbl[i], i);

    // The illegal p1 request must still have advanced the pointer to p0
    to_drive();
    use_model = 1'b1;
    req_valid = 2'b11;
    we        = 2'b00;
    op[0]     = 3'd2;
    op[1]     = 3'd2;
    addr[0]   = 32'h40;
    addr[1]   = 32'h44;
    to_neg();
    chk("pointer after illegal", rq_rdy, 2'b01);
    to_drive();
    req_valid = 2'b00;
    repeat (4) to_neg();

    // Backpressure: p0 response held while p1 waits
    to_drive();
    req_valid    = 2'b01;
    addr[0]      = 32'h30;
    rsp_ready    = 2'b00;
    to_neg();
    chk("B grant p0", rq_rdy, 2'b01);
    to_drive();
    req_valid    = 2'b10;
    addr[1]      = 32'h50;
    to_neg();
    chk("B issue p1 blocked", rq_rdy, 2'b00);
    to_neg();
    chk("B wait p1 blocked", rq_rdy, 2'b00);
    for (int k = 0; k < 5; k++) begin
      to_neg();
      chk($sformatf("B hold%0d rspValid", k), rs_vld, 2'b01);
      chk($sformatf("B hold%0d rdata", k), rdat[0], memf(32'h30, 3'd2));
      chk($sformatf("B hold%0d p1 blocked", k), rq_rdy, 2'b00);
    end
    to_drive();
    rsp_ready = 2'b01;
    to_neg();
    chk("B consume rspValid", rs_vld, 2'b01);
    chk("B consume p1 blocked", rq_rdy, 2'b00);
    to_neg();
    chk("B p1 granted", rq_rdy, 2'b10);
    to_drive();
    req_valid = 2'b00;
    rsp_ready = 2'b11;
    to_neg();
    to_neg();
    to_neg();
    chk("B p1 rdata", rdat[1], memf(32'h50, 3'd2));
    to_neg();

    // Reset during WAIT drops the transaction
    to_drive();
    req_valid = 2'b01;
    addr[0]   = 32'h60;
    to_neg();
    chk("C grant p0", rq_rdy, 2'b01);
    to_drive();
    req_valid = 2'b10;
    addr[1]   = 32'h70;
    to_neg();
    to_drive();
    rst = 1'b1;
    #1;
    chk_all_zero("C reset");
    to_neg();
    chk("C reset rspValid", rs_vld, 2'b00);
    to_drive();
    rst = 1'b0;
    to_neg();
    chk("C p1 granted first", rq_rdy, 2'b10);
    chk("C p0 no response", rs_vld, 2'b00);
    to_drive();
    req_valid = 2'b00;
    to_neg();
    to_neg();
    to_neg();
    chk("C p1 rspValid", rs_vld, 2'b10);
    chk("C p1 rdata", rdat[1], memf(32'h70, 3'd2));
    to_neg();

    // Randomized traffic against the transaction-level model
    to_drive();
    rst = 1'b1;
    idle_inputs();
    use_model = 1'b1;
    to_drive();
    rst     = 1'b0;
    m_busy  = 0;
    m_ptr   = 0;
    m_owner = 0;
    m_age   = 0;
    m_lat   = 0;
    m_err   = 0;
    m_we    = 0;
    m_addr  = '0;
    m_wdata = '0;
    m_op    = '0;
    m_rdata = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int n = 0; n < 2; n++) begin
        if (!req_valid[n] && $urandom_range(0, 2) == 0) begin
          req_valid[n] = 1'b1;
          op[n]        = 3'($urandom_range(0, 7));
          we[n]        = 1'($urandom_range(0, 1));
          addr[n]      = 32'($urandom_range(0, 255));
          wdata[n]     = $urandom;
        end
      end
      rsp_ready = 2'($urandom_range(0, 3));
      to_neg();
      granted = 0;
      g       = 0;
      if (!m_busy) begin
        exp_rdy = 2'b00;
        g = (req_valid == 2'b11) ? m_ptr : req_valid[1];
        if (req_valid != 2'b00) begin
          exp_rdy[g] = 1'b1;
          granted    = 1;
        end
        chk("R reqReady", rq_rdy, exp_rdy);
        chk("R idle rspValid", rs_vld, 2'b00);
        chk("R idle mem_we", bus.mem_we, 1'b0);
      end else begin
        chk("R busy reqReady", rq_rdy, 2'b00);
        chk("R rspValid", rs_vld, (m_age >= m_lat) ? (m_owner ? 2'b10 : 2'b01) : 2'b00);
        chk("R mem_we", bus.mem_we, m_age == 1 && !m_err && m_we);
        if (m_age == 1 && !m_err) begin
          chk("R mem_addr", bus.mem_addr, m_addr);
          chk("R mem_memOp", bus.mem_memOp, m_op);
          chk("R mem_din", bus.mem_din, m_wdata);
        end
        if (m_age >= m_lat) begin
          chk("R rdata", rdat[m_owner], m_rdata);
          chk("R rspErr", rs_err[m_owner], m_err);
        end
      end
      if (granted) begin
        m_busy  = 1;
        m_owner = g;
        m_ptr   = ~g;
        m_age   = 1;
        m_addr  = addr[g];
        m_wdata = wdata[g];
        m_op    = op[g];
        m_we    = we[g];
        m_err   = ref_illegal(op[g], addr[g]);
        m_lat   = m_err ? 1 : (m_we ? 2 : 3);
        m_rdata = (m_err || m_we) ? 32'h0 : memf(addr[g], op[g]);
      end else if (m_busy) begin
        if (m_age >= m_lat && rsp_ready[m_owner]) m_busy = 0;
        else if (m_age < m_lat) m_age++;
      end
      to_drive();
      if (granted) req_valid[g] = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter addrWidth, default 32, memory address width.
REQ-002 SHALL have parameter dataWidth, default 32, memory data width.
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL provide, per requester n in {0,1}, prefix pn_, the following ports:
- pn_reqValid, input, 1, request present.
- pn_reqReady, output, 1, request accepted this cycle.
- pn_addr, input, addrWidth, byte address.
- pn_wdata, input, dataWidth, store data.
- pn_memOp, input, 3, memory op code: 0 B, 1 H, 2 W, 4 BU, 5 HU.
- pn_we, input, 1, store when 1, load when 0.
- pn_rspValid, output, 1, response present.
- pn_rspReady, input, 1, response consumed.
- pn_rdata, output, dataWidth, load result; 0 for stores.
- pn_rspErr, output, 1, illegal or misaligned access.
REQ-006 SHALL provide the memory port mem_addr, output, addrWidth, to memory.
REQ-007 SHALL provide the memory port mem_din, output, dataWidth, to memory.
REQ-008 SHALL provide the memory port mem_memOp, output, 3, to memory.
REQ-009 SHALL provide the memory port mem_we, output, 1, to memory.
REQ-010 SHALL provide the memory port mem_dout, input, dataWidth, already extended per memOp, valid one cycle after issue.

Function
REQ-011 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP.
REQ-012 In IDLE with any reqValid, SHALL grant exactly one requester and pulse its reqReady for one cycle, then go to ISSUE.
REQ-013 SHALL register the request fields at grant and SHALL NOT sample requester inputs again until the next IDLE.
REQ-014 Arbitration SHALL be round-robin via a 1-bit priority pointer, reset 0.
- Pointer names the preferred requester.
- After each grant, pointer = other requester.
- With only one reqValid, that requester wins regardless of pointer.
REQ-015 In ISSUE, mem_addr, mem_din and mem_memOp SHALL present the latched fields.
- mem_we = latched we for exactly this cycle.
- mem_we = 0 in every other state.
REQ-016 Load SHALL go ISSUE -> WAIT, capture mem_dout at the end of WAIT, then go to RESP.
REQ-017 Store SHALL go ISSUE -> RESP with rdata = 0.
REQ-018 Error check SHALL run at grant.
- Illegal: memOp in {3,6,7}; H/HU with addr[0]=1; W with addr[1:0]!=0.
- An illegal request SHALL go IDLE -> RESP directly with rspErr=1 and rdata=0.
- mem_we SHALL stay 0 for an illegal request.
REQ-019 In RESP, only the granted requester's rspValid SHALL be 1.
- rdata and rspErr SHALL be held stable.
- Exit to IDLE on the cycle rspReady=1.
- Hold indefinitely otherwise.
REQ-020 SHALL keep one outstanding transaction at most.
- Both reqReady = 0 outside IDLE.
- Minimum turnaround: load 4 cycles, store 3 cycles, grant to IDLE, rspReady already high.
REQ-021 A requester SHALL be able to assert a new reqValid during its own RESP; it is considered in the next IDLE.
REQ-022 rspReady on a non-granted requester, or outside RESP, SHALL be ignored.
REQ-023 When idle, mem_addr, mem_din and mem_memOp SHALL hold last latched values (0 after reset).

Reset
REQ-024 Asserting rst SHALL immediately force the following, at any time including mid-transaction, and SHALL drop the in-flight transaction with no response:
- state IDLE, pointer 0;
- all reqReady and rspValid = 0;
- mem_we = 0;
- latched fields, rdata and rspErr = 0.

Verification
REQ-025 Bench SHALL cover contention: p0 and p1 LW valid together from reset, addr 0x10/0x20 -> p0 served first (mem_addr 0x10), then p1 (0x20), strictly serialized.
REQ-026 Bench SHALL cover a store then a load: p1 SW addr 0x8 wdata 0xDEADBEEF -> mem_we high exactly 1 cycle with mem_din 0xDEADBEEF; then p1 LW 0x8 with mem_dout 0xDEADBEEF -> p1_rdata 0xDEADBEEF, rspErr 0.
REQ-027 Bench SHALL cover misalignment: p0 LH addr 0x3 -> rspErr 1, rdata 0, mem_we never asserted; response 1 cycle after grant.
REQ-028 Bench SHALL cover backpressure: p0 load, rspReady held 0 for 5 cycles -> rspValid and rdata stable throughout; p1 reqReady stays 0 until p0 consumes.
REQ-029 Bench SHALL cover reset mid-operation: rst asserted in WAIT -> all outputs 0 immediately, no response delivered; after release, a fresh p1-only request is granted first.
REQ-030 Bench SHALL cover illegal op: memOp 3 from p1 -> rspErr 1, no memory access; pointer still advances.
